acc_datapath_p: RTL and testbench
=================================

// Module: acc_datapath_p
// PURPOSE
//  Parametrised accumulator datapath for the FlexiCore family: accumulator A, register file, ALU and PC.
//  Adds three things to the fixed 4-bit datapath: a handshaked input port, a strobed output port, and a
//  hardware return-address stack (CALL/RET). Sits between the instruction decoder (control inputs) and
//  the program ROM (PC output); executes one instruction per cycle except when stalled on the input port.
// PARAMETERS
//  DATA_LEN    4  accumulator/register/port width
//  PC_LEN      8  program counter width
//  NUM_REGS    8  register file entries (>=2; reg0=output port, reg1=input port)
//  REG_ID_LEN  3  REG_ID width; must satisfy 2**REG_ID_LEN >= NUM_REGS
//  RAS_DEPTH   4  return-address stack entries (>=1)
//  ALU_OP_LEN  3  ALU opcode width, as decoded by the existing alu block
// PORTS
//  CLK          in   1           clock, rising edge
//  RSTN         in   1           asynchronous active-low reset
//  PC           out  PC_LEN      current program counter
//  IPORT        in   DATA_LEN    input port data, read as reg1
//  IPORT_VALID  in   1           IPORT holds a fresh value
//  IPORT_ACK    out  1           comb: IPORT consumed this cycle
//  OPORT        out  DATA_LEN    reg0 contents
//  OPORT_STB    out  1           one-cycle pulse, cycle after reg0 is written
//  ALU_OP       in   ALU_OP_LEN  ALU operation
//  INSTR_IMM    in   DATA_LEN    immediate operand
//  IMM_SEL      in   1           1: ALU B = INSTR_IMM; 0: ALU B = reg[REG_ID]
//  BR_TARGET    in   PC_LEN      jump/branch/call target
//  IS_BRANCH    in   1           unconditional jump
//  IS_BRN       in   1           branch if A negative
//  IS_BRZ       in   1           branch if A zero
//  IS_BRP       in   1           branch if A strictly positive
//  IS_LD        in   1           A <= reg[REG_ID]
//  IS_ST        in   1           reg[REG_ID] <= A
//  IS_CALL      in   1           push return address, jump to BR_TARGET
//  IS_RET       in   1           pop return address into PC
//  REG_ID       in   REG_ID_LEN  register select
//  STALL        out  1           comb: instruction held, no state change
//  STK_ERR      out  1           sticky: stack overflow or underflow seen
// BEHAVIOUR
//  Reset (RSTN low, async): PC=0, A=0, all regs=0, OPORT=0, OPORT_STB=0, STK_ERR=0, stack empty.
//    STALL and IPORT_ACK are forced to 0 while RSTN is low.
//  Control inputs are one-hot. If they are not, priority is RET > CALL > BRANCH > BRN/BRZ/BRP > ST > LD > ALU.
//  Input-port read: (IS_LD, or ALU op with IMM_SEL=0) and REG_ID==1.
//    Read with IPORT_VALID=0: STALL=1; PC, A, regs and stack hold. The decoder re-presents the instruction.
//    Read with IPORT_VALID=1: IPORT_ACK=1 in the same cycle and the instruction completes.
//  A update:
//    IS_LD -> reg[REG_ID].
//    ALU op (no IS_* set) -> alu(A, B, ALU_OP), result truncated to DATA_LEN.
//    All other instructions leave A unchanged.
//  Store: reg[REG_ID] <= A on the next edge.
//    REG_ID==1 or REG_ID>=NUM_REGS: write dropped.
//    Reads of REG_ID>=NUM_REGS return 0.
//  Conditions on A: N = A[MSB]; Z = ~|A; P = ~A[MSB] & |A.
//  PC next:
//    taken branch / IS_BRANCH / IS_CALL -> BR_TARGET
//    IS_RET -> popped entry
//    stall -> PC
//    otherwise -> PC+1, wrapping modulo 2**PC_LEN.
//  CALL: push (PC+1) mod 2**PC_LEN.
//    Stack full: the oldest entry is overwritten (circular), the depth stays RAS_DEPTH, STK_ERR <= 1.
//  RET with empty stack: PC <= PC+1 and STK_ERR <= 1.
//  STK_ERR clears only on reset.
//  OPORT_STB: registered; high exactly one cycle after a store to reg0. Back-to-back stores give back-to-back pulses.
// TESTING
//  1. Reset mid-run with PC=0x37, A=0x9: assert RSTN low between edges -> PC=0, A=0, OPORT=0 immediately.
//  2. LD r1 with IPORT_VALID=0 for 3 cycles, then VALID=1 and IPORT=0xA:
//     -> STALL=1 for 3 cycles with PC held; IPORT_ACK pulses once; A=0xA; PC advances by 1.
//  3. A=0x8: BRN to 0x20 -> PC=0x20. Same instruction with A=0x0 -> PC+1. A=0x0: BRZ taken; BRP not taken.
//  4. RAS_DEPTH=4: CALLs from PCs 0x10,0x20,0x30,0x40,0x50, then 5 RETs.
//     -> PCs 0x51,0x41,0x31,0x21, then PC+1 on the 5th RET.
//     -> STK_ERR=1 from the 5th CALL onward.
//  5. ST r0 with A=0x5 -> OPORT=0x5 and OPORT_STB high for exactly one cycle.
//     ST r1 -> no change anywhere. ST r9 with NUM_REGS=8 -> dropped.
//  6. PC=0xFF, PC_LEN=8: ALU op -> PC=0x00. CALL at 0xFF pushes 0x00.

Source files
------------

// File: rtl/acc_datapath_p_if.sv
// ----------------------------------------------------------------------------
// acc_datapath_p_if
// Bundle between the instruction decoder / I/O fabric and the accumulator
// datapath. The master is the decoder side: it drives the decoded control
// word and the input port, and it sees PC, the output port and the status
// flags. The slave is the datapath itself.
//
// Signals (direction seen from the slave):
//   PC           out  current program counter (to the program ROM)
//   IPORT        in   input port data, read as reg1
//   IPORT_VALID  in   IPORT holds a fresh value
//   IPORT_ACK    out  IPORT consumed this cycle (combinational)
//   OPORT        out  reg0 contents
//   OPORT_STB    out  one-cycle pulse the cycle after reg0 is written
//   ALU_OP       in   ALU operation
//   INSTR_IMM    in   immediate operand
//   IMM_SEL      in   1: ALU B = INSTR_IMM, 0: ALU B = reg[REG_ID]
//   BR_TARGET    in   jump/branch/call target
//   IS_*         in   one-hot instruction class flags
//   REG_ID       in   register select
//   STALL        out  instruction held, no state change (combinational)
//   STK_ERR      out  sticky return-stack overflow/underflow flag
// ----------------------------------------------------------------------------
interface acc_datapath_p_if #(
    parameter int DATA_LEN   = 4,
    parameter int PC_LEN     = 8,
    parameter int REG_ID_LEN = 3,
    parameter int ALU_OP_LEN = 3
);
    logic [PC_LEN-1:0]     PC;
    logic [DATA_LEN-1:0]   IPORT;
    logic                  IPORT_VALID;
    logic                  IPORT_ACK;
    logic [DATA_LEN-1:0]   OPORT;
    logic                  OPORT_STB;
    logic [ALU_OP_LEN-1:0] ALU_OP;
    logic [DATA_LEN-1:0]   INSTR_IMM;
    logic                  IMM_SEL;
    logic [PC_LEN-1:0]     BR_TARGET;
    logic                  IS_BRANCH;
    logic                  IS_BRN;
    logic                  IS_BRZ;
    logic                  IS_BRP;
    logic                  IS_LD;
    logic                  IS_ST;
    logic                  IS_CALL;
    logic                  IS_RET;
    logic [REG_ID_LEN-1:0] REG_ID;
    logic                  STALL;
    logic                  STK_ERR;

    modport master (
        input  PC, IPORT_ACK, OPORT, OPORT_STB, STALL, STK_ERR,
        output IPORT, IPORT_VALID, ALU_OP, INSTR_IMM, IMM_SEL, BR_TARGET,
               IS_BRANCH, IS_BRN, IS_BRZ, IS_BRP, IS_LD, IS_ST, IS_CALL,
               IS_RET, REG_ID
    );

    modport slave (
        output PC, IPORT_ACK, OPORT, OPORT_STB, STALL, STK_ERR,
        input  IPORT, IPORT_VALID, ALU_OP, INSTR_IMM, IMM_SEL, BR_TARGET,
               IS_BRANCH, IS_BRN, IS_BRZ, IS_BRP, IS_LD, IS_ST, IS_CALL,
               IS_RET, REG_ID
    );
endinterface

// File: rtl/acc_datapath_p.sv
// ----------------------------------------------------------------------------
// acc_datapath_p
// Parametrised FlexiCore accumulator datapath: accumulator A, register file,
// ALU, program counter, handshaked input port (reg1), strobed output port
// (reg0) and a circular hardware return-address stack for CALL/RET.
// One instruction per cycle; an instruction reading reg1 while IPORT_VALID
// is low stalls with no state change until the decoder re-presents it.
//
// Ports:
//   CLK   in  clock, rising edge
//   RSTN  in  asynchronous active-low reset
//   bus   slave side of acc_datapath_p_if (control word, ports, status)
//
// ALU_OP encoding:
//   0 A+B   1 A-B   2 A&B   3 A|B   4 A^B   5 ~A   6 B   7 A<<1
// ----------------------------------------------------------------------------
module acc_datapath_p #(
    parameter int DATA_LEN   = 4,
    parameter int PC_LEN     = 8,
    parameter int NUM_REGS   = 8,
    parameter int REG_ID_LEN = 3,
    parameter int RAS_DEPTH  = 4,
    parameter int ALU_OP_LEN = 3
) (
    input  logic             CLK,
    input  logic             RSTN,
    acc_datapath_p_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    function automatic logic [DATA_LEN-1:0] alu(
        input logic [DATA_LEN-1:0]   a,
        input logic [DATA_LEN-1:0]   b,
        input logic [ALU_OP_LEN-1:0] op
    );
        logic [DATA_LEN-1:0] r;
        case (int'(op))
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = a ^ b;
            5:       r = ~a;
            6:       r = b;
            7:       r = a << 1;
            default: r = a;
        endcase
        return r;
    endfunction

    logic [PC_LEN-1:0]   pc_q, pc_d;
    logic [DATA_LEN-1:0] a_q, a_d;
    logic [DATA_LEN-1:0] regs_q [NUM_REGS];
    logic [DATA_LEN-1:0] regs_d [NUM_REGS];
    logic [PC_LEN-1:0]   ras_q  [RAS_DEPTH];
    logic [PC_LEN-1:0]   ras_d  [RAS_DEPTH];
    logic [PTR_W-1:0]    ptr_q, ptr_d;      // next free slot
    logic [CNT_W-1:0]    cnt_q, cnt_d;      // live entries, saturates at RAS_DEPTH
    logic                stb_q, stb_d;
    logic                err_q, err_d;

    // Priority decode: RET > CALL > BRANCH > BRN/BRZ/BRP > ST > LD > ALU.
    logic any_cond, do_ret, do_call, do_jmp, do_cond, do_st, do_ld, do_alu;
    assign any_cond = bus.IS_BRN | bus.IS_BRZ | bus.IS_BRP;
    assign do_ret   = bus.IS_RET;
    assign do_call  = ~bus.IS_RET & bus.IS_CALL;
    assign do_jmp   = ~(bus.IS_RET | bus.IS_CALL) & bus.IS_BRANCH;
    assign do_cond  = ~(bus.IS_RET | bus.IS_CALL | bus.IS_BRANCH) & any_cond;
    assign do_st    = ~(bus.IS_RET | bus.IS_CALL | bus.IS_BRANCH | any_cond) & bus.IS_ST;
    assign do_ld    = ~(bus.IS_RET | bus.IS_CALL | bus.IS_BRANCH | any_cond | bus.IS_ST)
                      & bus.IS_LD;
    assign do_alu   = ~(bus.IS_RET | bus.IS_CALL | bus.IS_BRANCH | any_cond | bus.IS_ST
                        | bus.IS_LD);

    logic                rid_is_port, rid_valid;
    logic [IDX_W-1:0]    rid_idx;
    logic [DATA_LEN-1:0] rd_data, alu_b;
    assign rid_is_port = (bus.REG_ID == REG_ID_LEN'(1));
    assign rid_valid   = (int'(bus.REG_ID) < NUM_REGS);
    assign rid_idx     = IDX_W'(bus.REG_ID);

    // reg1 is the input port itself; ids past the file read as zero.
    always_comb begin
        rd_data = '0;
        if (rid_is_port)
            rd_data = bus.IPORT;
        else if (rid_valid)
            rd_data = regs_q[rid_idx];
    end

    assign alu_b = bus.IMM_SEL ? bus.INSTR_IMM : rd_data;

    logic rd_port, stall, ack;
    assign rd_port = (do_ld | (do_alu & ~bus.IMM_SEL)) & rid_is_port;
    assign stall   = rd_port & ~bus.IPORT_VALID & RSTN;
    assign ack     = rd_port &  bus.IPORT_VALID & RSTN;

    logic a_neg, a_zero, a_pos, taken;
    assign a_neg  = a_q[DATA_LEN-1];
    assign a_zero = ~|a_q;
    assign a_pos  = ~a_neg & ~a_zero;
    assign taken  = (bus.IS_BRN & a_neg) | (bus.IS_BRZ & a_zero) | (bus.IS_BRP & a_pos);

    logic [PC_LEN-1:0] pc_inc;
    logic [PTR_W-1:0]  ptr_next, ptr_prev;
    assign pc_inc   = pc_q + PC_LEN'(1);
    assign ptr_next = (ptr_q == PTR_MAX) ? '0 : ptr_q + PTR_W'(1);
    assign ptr_prev = (ptr_q == '0) ? PTR_MAX : ptr_q - PTR_W'(1);

    always_comb begin
        pc_d   = pc_q;
        a_d    = a_q;
        regs_d = regs_q;
        ras_d  = ras_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        stb_d  = 1'b0;
        err_d  = err_q;
        if (stall) begin
            pc_d = pc_q;
        end else if (do_ret) begin
            if (cnt_q != '0) begin
                pc_d  = ras_q[ptr_prev];
                ptr_d = ptr_prev;
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                pc_d  = pc_inc;
                err_d = 1'b1;
            end
        end else if (do_call) begin
            // A full stack keeps its depth; the write lands on the oldest slot.
            ras_d[ptr_q] = pc_inc;
            ptr_d        = ptr_next;
            if (cnt_q == CNT_FULL)
                err_d = 1'b1;
            else
                cnt_d = cnt_q + CNT_W'(1);
            pc_d = bus.BR_TARGET;
        end else if (do_jmp) begin
            pc_d = bus.BR_TARGET;
        end else if (do_cond) begin
            pc_d = taken ? bus.BR_TARGET : pc_inc;
        end else if (do_st) begin
            if (!rid_is_port && rid_valid)
                regs_d[rid_idx] = a_q;
            stb_d = (bus.REG_ID == '0);
            pc_d  = pc_inc;
        end else if (do_ld) begin
            a_d  = rd_data;
            pc_d = pc_inc;
        end else begin
            a_d  = alu(a_q, alu_b, bus.ALU_OP);
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pc_q  <= '0;
            a_q   <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            stb_q <= 1'b0;
            err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)  regs_q[i] <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i]  <= '0;
        end else begin
            pc_q   <= pc_d;
            a_q    <= a_d;
            regs_q <= regs_d;
            ras_q  <= ras_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            stb_q  <= stb_d;
            err_q  <= err_d;
        end
    end

    assign bus.PC        = pc_q;
    assign bus.OPORT     = regs_q[0];
    assign bus.OPORT_STB = stb_q;
    assign bus.STK_ERR   = err_q;
    assign bus.STALL     = stall;
    assign bus.IPORT_ACK = ack;
endmodule

// File: tb/tb_acc_datapath_p.sv
// ----------------------------------------------------------------------------
// tb_acc_datapath_p
// Self-checking bench for acc_datapath_p: a table of directed instructions
// with hand-derived results, hand-written multi-cycle sequences (input stall,
// return stack, PC wrap, asynchronous reset) and a randomized run compared
// against a behavioural model built on integers and a queue-based stack.
// REG_ID_LEN is 4 here so that ids beyond the 8-entry file can be issued.
// ----------------------------------------------------------------------------
module tb_acc_datapath_p;
    localparam int DL  = 4;
    localparam int PL  = 8;
    localparam int NR  = 8;
    localparam int RL  = 4;
    localparam int RD  = 4;
    localparam int AL  = 3;
    localparam int DMOD = 1 << DL;
    localparam int PMOD = 1 << PL;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    acc_datapath_p_if #(.DATA_LEN(DL), .PC_LEN(PL), .REG_ID_LEN(RL), .ALU_OP_LEN(AL)) bus ();

    acc_datapath_p #(
        .DATA_LEN(DL), .PC_LEN(PL), .NUM_REGS(NR), .REG_ID_LEN(RL),
        .RAS_DEPTH(RD), .ALU_OP_LEN(AL)
    ) dut (
        .CLK (clk),
        .RSTN(rstn),
        .bus (bus)
    );

    typedef struct {
        int op, imm, isel, tgt;
        int br, brn, brz, brp, ld, st, call, ret;
        int rid, iport, ivld;
    } ins_t;

    typedef struct {
        ins_t i;
        int   pc, oport, stb, stall, ack;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int m_pc, m_a;
    int m_reg [16];
    int m_stk [$];
    int m_err, m_stb;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ins_t blank();
        ins_t x = '{default: 0};
        return x;
    endfunction
    function automatic ins_t i_alu(input int op, input int imm);
        ins_t x = blank(); x.op = op; x.imm = imm; x.isel = 1; return x;
    endfunction
    function automatic ins_t i_alu_r(input int op, input int rid, input int ip, input int v);
        ins_t x = blank(); x.op = op; x.rid = rid; x.iport = ip; x.ivld = v; return x;
    endfunction
    function automatic ins_t i_ld(input int rid, input int ip, input int v);
        ins_t x = blank(); x.ld = 1; x.rid = rid; x.iport = ip; x.ivld = v; return x;
    endfunction
    function automatic ins_t i_st(input int rid);
        ins_t x = blank(); x.st = 1; x.rid = rid; return x;
    endfunction
    function automatic ins_t i_br(input int t);
        ins_t x = blank(); x.br = 1; x.tgt = t; return x;
    endfunction
    // kind: 0 = BRN, 1 = BRZ, 2 = BRP
    function automatic ins_t i_cond(input int kind, input int t);
        ins_t x = blank(); x.tgt = t;
        x.brn = (kind == 0); x.brz = (kind == 1); x.brp = (kind == 2);
        return x;
    endfunction
    function automatic ins_t i_call(input int t);
        ins_t x = blank(); x.call = 1; x.tgt = t; return x;
    endfunction
    function automatic ins_t i_ret();
        ins_t x = blank(); x.ret = 1; return x;
    endfunction

    task automatic drive(input ins_t i);
        bus.ALU_OP      = AL'(i.op);
        bus.INSTR_IMM   = DL'(i.imm);
        bus.IMM_SEL     = i.isel[0];
        bus.BR_TARGET   = PL'(i.tgt);
        bus.IS_BRANCH   = i.br[0];
        bus.IS_BRN      = i.brn[0];
        bus.IS_BRZ      = i.brz[0];
        bus.IS_BRP      = i.brp[0];
        bus.IS_LD       = i.ld[0];
        bus.IS_ST       = i.st[0];
        bus.IS_CALL     = i.call[0];
        bus.IS_RET      = i.ret[0];
        bus.REG_ID      = RL'(i.rid);
        bus.IPORT       = DL'(i.iport);
        bus.IPORT_VALID = i.ivld[0];
    endtask

    function automatic void model_reset();
        m_pc = 0; m_a = 0; m_err = 0; m_stb = 0;
        foreach (m_reg[k]) m_reg[k] = 0;
        m_stk.delete();
    endfunction

    // Instruction class after priority: 0 RET, 1 CALL, 2 BRANCH, 3 cond, 4 ST, 5 LD, 6 ALU
    function automatic int cls(input ins_t i);
        if (i.ret != 0)                         return 0;
        if (i.call != 0)                        return 1;
        if (i.br != 0)                          return 2;
        if ((i.brn | i.brz | i.brp) != 0)       return 3;
        if (i.st != 0)                          return 4;
        if (i.ld != 0)                          return 5;
        return 6;
    endfunction

    function automatic int rd_reg(input int id, input int ip);
        if (id == 1) return ip;
        if (id < NR) return m_reg[id];
        return 0;
    endfunction

    function automatic int alu_ref(input int a, input int b, input int op);
        case (op)
            0: return (a + b) % DMOD;
            1: return (a - b + DMOD) % DMOD;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (DMOD - 1) - a;
            6: return b;
            default: return (a * 2) % DMOD;
        endcase
    endfunction

    function automatic int reads_port(input ins_t i);
        int c = cls(i);
        return ((c == 5 || (c == 6 && i.isel == 0)) && i.rid == 1) ? 1 : 0;
    endfunction

    function automatic void model_step(input ins_t i);
        int c = cls(i);
        int nxt = (m_pc + 1) % PMOD;
        m_stb = 0;
        if (reads_port(i) != 0 && i.ivld == 0) return;
        case (c)
            0: begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_pc = nxt; m_err = 1; end
            end
            1: begin
                m_stk.push_back(nxt);
                if (m_stk.size() > RD) begin void'(m_stk.pop_front()); m_err = 1; end
                m_pc = i.tgt;
            end
            2: m_pc = i.tgt;
            3: begin
                int half = DMOD / 2;
                if ((i.brn != 0 && m_a >= half) || (i.brz != 0 && m_a == 0) ||
                    (i.brp != 0 && m_a > 0 && m_a < half))
                    m_pc = i.tgt;
                else
                    m_pc = nxt;
            end
            4: begin
                if (i.rid != 1 && i.rid < NR) m_reg[i.rid] = m_a;
                if (i.rid == 0) m_stb = 1;
                m_pc = nxt;
            end
            5: begin m_a = rd_reg(i.rid, i.iport); m_pc = nxt; end
            default: begin
                m_a = alu_ref(m_a, (i.isel != 0) ? i.imm : rd_reg(i.rid, i.iport), i.op);
                m_pc = nxt;
            end
        endcase
    endfunction

    // One instruction: present at negedge, check comb outputs, clock it, check state.
    task automatic apply(input ins_t i);
        int rp;
        @(negedge clk);
        drive(i);
        #1;
        rp = reads_port(i);
        chk("stall", int'(bus.STALL), (rp != 0 && i.ivld == 0) ? 1 : 0);
        chk("iport_ack", int'(bus.IPORT_ACK), (rp != 0 && i.ivld != 0) ? 1 : 0);
        model_step(i);
        @(posedge clk);
        #1;
        chk("pc", int'(bus.PC), m_pc);
        chk("oport", int'(bus.OPORT), m_reg[0]);
        chk("oport_stb", int'(bus.OPORT_STB), m_stb);
        chk("stk_err", int'(bus.STK_ERR), m_err);
    endtask

    function automatic ins_t rnd_ins();
        ins_t x = blank();
        int k = $urandom_range(0, 9);
        x.op    = $urandom_range(0, 7);
        x.imm   = $urandom_range(0, DMOD - 1);
        x.isel  = $urandom_range(0, 1);
        x.tgt   = $urandom_range(0, PMOD - 1);
        x.rid   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : $urandom_range(0, 15);
        x.iport = $urandom_range(0, DMOD - 1);
        x.ivld  = $urandom_range(0, 1);
        case (k)
            0: x.ret  = 1;
            1: x.call = 1;
            2: x.br   = ($urandom_range(0, 3) == 0) ? 1 : 0;
            3: x.brn  = 1;
            4: x.brz  = 1;
            5: x.brp  = 1;
            6: x.st   = 1;
            7: x.ld   = 1;
            default: ;
        endcase
        // Occasionally a non-one-hot word to exercise the priority order.
        if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
                0: x.ld = 1;
                1: x.st = 1;
                2: x.brz = 1;
                default: x.call = 1;
            endcase
        end
        return x;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t tab [21];
        ins_t idle;
        int   exp_call_err [5];
        int   exp_ret_pc   [5];

        tab[0]  = '{i_alu(6, 5),         'h01, 'h0, 0, 0, 0};
        tab[1]  = '{i_st(0),             'h02, 'h5, 1, 0, 0};
        tab[2]  = '{i_alu(0, 3),         'h03, 'h5, 0, 0, 0};
        tab[3]  = '{i_cond(0, 'h20),     'h20, 'h5, 0, 0, 0};
        tab[4]  = '{i_alu(1, 8),         'h21, 'h5, 0, 0, 0};
        tab[5]  = '{i_cond(0, 'h40),     'h22, 'h5, 0, 0, 0};
        tab[6]  = '{i_cond(2, 'h40),     'h23, 'h5, 0, 0, 0};
        tab[7]  = '{i_cond(1, 'h30),     'h30, 'h5, 0, 0, 0};
        tab[8]  = '{i_alu(6, 7),         'h31, 'h5, 0, 0, 0};
        tab[9]  = '{i_st(1),             'h32, 'h5, 0, 0, 0};
        tab[10] = '{i_st(9),             'h33, 'h5, 0, 0, 0};
        tab[11] = '{i_ld(9, 0, 0),       'h34, 'h5, 0, 0, 0};
        tab[12] = '{i_st(0),             'h35, 'h0, 1, 0, 0};
        tab[13] = '{i_alu_r(0, 1, 3, 1), 'h36, 'h0, 0, 0, 1};
        tab[14] = '{i_st(0),             'h37, 'h3, 1, 0, 0};
        tab[15] = '{i_st(0),             'h38, 'h3, 1, 0, 0};
        tab[16] = '{i_alu(4, 15),        'h39, 'h3, 0, 0, 0};
        tab[17] = '{i_st(2),             'h3A, 'h3, 0, 0, 0};
        tab[18] = '{i_alu(6, 0),         'h3B, 'h3, 0, 0, 0};
        tab[19] = '{i_ld(2, 0, 0),       'h3C, 'h3, 0, 0, 0};
        tab[20] = '{i_st(0),             'h3D, 'hC, 1, 0, 0};

        exp_call_err = '{0, 0, 0, 0, 1};
        exp_ret_pc   = '{'h51, 'h41, 'h31, 'h21, 'h22};

        // Stalled read of reg1: holds all state while the reset edge passes.
        idle = i_ld(1, 0, 0);

        // Power-on reset
        rstn = 1'b0;
        drive(idle);
        model_reset();
        #2;
        chk("rst_pc", int'(bus.PC), 0);
        chk("rst_oport", int'(bus.OPORT), 0);
        chk("rst_stb", int'(bus.OPORT_STB), 0);
        chk("rst_stk_err", int'(bus.STK_ERR), 0);
        chk("rst_stall", int'(bus.STALL), 0);
        chk("rst_ack", int'(bus.IPORT_ACK), 0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed table
        for (int k = 0; k < 21; k++) begin
            apply(tab[k].i);
            chk("tab_pc", int'(bus.PC), tab[k].pc);
            chk("tab_oport", int'(bus.OPORT), tab[k].oport);
            chk("tab_stb", int'(bus.OPORT_STB), tab[k].stb);
            chk("tab_stall", int'(bus.STALL), tab[k].stall);
            chk("tab_ack", int'(bus.IPORT_ACK), tab[k].ack);
        end

        // Input-port stall: three cycles without data, then data 0xA
        for (int k = 0; k < 3; k++) begin
            apply(i_ld(1, 0, 0));
            chk("stall_hold_pc", int'(bus.PC), 'h3D);
            chk("stall_flag", int'(bus.STALL), 1);
        end
        apply(i_ld(1, 'hA, 1));
        chk("stall_done_pc", int'(bus.PC), 'h3E);
        chk("stall_done_ack", int'(bus.IPORT_ACK), 1);
        apply(i_st(0));
        chk("stall_a_value", int'(bus.OPORT), 'hA);
        chk("ack_single", int'(bus.IPORT_ACK), 0);

        // PC wrap and CALL at 0xFF pushing 0x00
        apply(i_br('hFF));
        apply(i_alu(0, 0));
        chk("wrap_pc", int'(bus.PC), 'h00);
        apply(i_br('hFF));
        apply(i_call('h80));
        chk("wrap_call_pc", int'(bus.PC), 'h80);
        apply(i_ret());
        chk("wrap_ret_pc", int'(bus.PC), 'h00);
        chk("wrap_no_err", int'(bus.STK_ERR), 0);

        // Return stack: five CALLs into a four-deep stack, then five RETs
        apply(i_br('h10));
        for (int k = 0; k < 5; k++) begin
            apply(i_call('h20 + 'h10 * k));
            chk("call_pc", int'(bus.PC), 'h20 + 'h10 * k);
            chk("call_err", int'(bus.STK_ERR), exp_call_err[k]);
        end
        for (int k = 0; k < 5; k++) begin
            apply(i_ret());
            chk("ret_pc", int'(bus.PC), exp_ret_pc[k]);
            chk("ret_err", int'(bus.STK_ERR), 1);
        end

        // Asynchronous reset between edges with PC=0x37, A=0x9
        apply(i_br('h35));
        apply(i_alu(6, 9));
        apply(i_st(0));
        chk("pre_rst_pc", int'(bus.PC), 'h37);
        chk("pre_rst_oport", int'(bus.OPORT), 'h9);
        #2;
        drive(idle);
        rstn = 1'b0;
        #1;
        chk("async_rst_pc", int'(bus.PC), 0);
        chk("async_rst_oport", int'(bus.OPORT), 0);
        chk("async_rst_stb", int'(bus.OPORT_STB), 0);
        chk("async_rst_err", int'(bus.STK_ERR), 0);
        chk("async_rst_stall", int'(bus.STALL), 0);
        chk("async_rst_ack", int'(bus.IPORT_ACK), 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        apply(i_alu(0, 1));
        apply(i_st(0));
        chk("post_rst_a", int'(bus.OPORT), 1);
        apply(i_ret());
        chk("post_rst_empty_stack", int'(bus.STK_ERR), 1);

        // Randomized run against the model
        for (int k = 0; k < 400; k++)
            apply(rnd_ins());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
